// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared IF-stage constants (reset PC, bubble encoding, opcodes).
package fetch_stage_pkg;
    localparam logic [31:0] PC_RESET   = 32'h4000_0000;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
    localparam logic [6:0]  OPC_OPIMM  = 7'h13;
    localparam logic [6:0]  OPC_BRANCH = 7'h63;
    localparam logic [6:0]  OPC_JAL    = 7'h6f;
    localparam logic [6:0]  OPC_JALR   = 7'h67;
endpackage

// File: rtl/fetch_stage_pc_gen.sv
// fetch_stage_pc_gen: PC register and next-PC priority mux feeding the icache.
module fetch_stage_pc_gen
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_nop_sel,
    output logic [31:0] o_pc_q,
    output logic [31:0] o_pc_next
);
    logic [31:0] r_pc;
    logic [31:0] w_target;

    assign w_target = i_redirect_pc & ~32'h3;
    // stall and nop_sel both re-present pc_q so the squashed word is fetched again
    always_comb
        o_pc_next = rst              ? RESET_PC :
                    i_stall          ? r_pc :
                    i_redirect_valid ? w_target :
                    i_nop_sel        ? r_pc : r_pc + 32'd4;

    always_ff @(posedge clk)
        r_pc <= o_pc_next;

    assign o_pc_q = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage - PC generation, IF/EX instruction register, bubble injection
// and fetch/bubble performance counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET,
    parameter logic [31:0] NOP_INST = INST_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_nop_sel,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic [31:0] i_icache_dout,
    output logic [31:0] o_icache_addr,
    output logic        o_icache_re,
    output logic [31:0] o_prev_inst,
    output logic [31:0] o_ex_pc,
    output logic        o_ex_valid,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_bubble_cnt
);
    logic [31:0] w_pc_q;
    logic [31:0] w_pc_next;
    logic        w_kill;
    logic [31:0] r_prev_inst;
    logic [31:0] r_ex_pc;
    logic        r_ex_valid;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    fetch_stage_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk             (clk),
        .rst             (rst),
        .i_stall         (i_stall),
        .i_redirect_valid(i_redirect_valid),
        .i_redirect_pc   (i_redirect_pc),
        .i_nop_sel       (i_nop_sel),
        .o_pc_q          (w_pc_q),
        .o_pc_next       (w_pc_next)
    );

    assign w_kill = i_nop_sel | i_redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_inst  <= NOP_INST;
            r_ex_pc      <= RESET_PC;
            r_ex_valid   <= 1'b0;
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (!i_stall) begin
            r_prev_inst  <= w_kill ? NOP_INST : i_icache_dout;
            r_ex_pc      <= w_pc_q;
            r_ex_valid   <= !w_kill;
            r_fetch_cnt  <= r_fetch_cnt + {31'd0, !w_kill};
            r_bubble_cnt <= r_bubble_cnt + {31'd0, w_kill};
        end
    end

    assign o_icache_addr = w_pc_next;
    assign o_icache_re   = !rst;
    assign o_prev_inst   = r_prev_inst;
    assign o_ex_pc       = r_ex_pc;
    assign o_ex_valid    = r_ex_valid;
    assign o_fetch_cnt   = r_fetch_cnt;
    assign o_bubble_cnt  = r_bubble_cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus against a cycle-level reference model
// of the fetch stage, with an address-tagged synchronous icache.
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        nop_sel = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] icache_dout;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] prev_inst;
    logic [31:0] ex_pc;
    logic        ex_valid;
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;

    int total = 0;
    int bad = 0;

    logic [31:0] mem_addr = '0;
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_prev = NOP;
    logic [31:0] m_ex_pc = RST_PC;
    logic        m_valid = 1'b0;
    logic [31:0] m_fetch = '0;
    logic [31:0] m_bubble = '0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .i_stall         (stall),
        .i_nop_sel       (nop_sel),
        .i_redirect_valid(redirect_valid),
        .i_redirect_pc   (redirect_pc),
        .i_icache_dout   (icache_dout),
        .o_icache_addr   (icache_addr),
        .o_icache_re     (icache_re),
        .o_prev_inst     (prev_inst),
        .o_ex_pc         (ex_pc),
        .o_ex_valid      (ex_valid),
        .o_fetch_cnt     (fetch_cnt),
        .o_bubble_cnt    (bubble_cnt)
    );

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) mem_addr <= icache_addr;
    assign icache_dout = tag(mem_addr);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One cycle: drive inputs, check the combinational fetch address, then the registers.
    task automatic step(input logic r, input logic s, input logic n, input logic rv,
                        input logic [31:0] rpc);
        logic [31:0] nxt;
        logic        kill;
        @(negedge clk);
        rst = r; stall = s; nop_sel = n; redirect_valid = rv; redirect_pc = rpc;
        #1;
        if (r)       nxt = RST_PC;
        else if (s)  nxt = m_pc;
        else if (rv) nxt = {rpc[31:2], 2'b00};
        else if (n)  nxt = m_pc;
        else         nxt = m_pc + 32'd4;
        chk("icache_addr", icache_addr, nxt);
        chk("icache_re", {31'd0, icache_re}, {31'd0, !r});
        @(posedge clk);
        #1;
        kill = n | rv;
        if (r) begin
            m_prev = NOP; m_ex_pc = RST_PC; m_valid = 1'b0; m_fetch = '0; m_bubble = '0;
        end else if (!s) begin
            m_prev   = kill ? NOP : tag(m_pc);
            m_ex_pc  = m_pc;
            m_valid  = !kill;
            m_fetch  = m_fetch + (kill ? 32'd0 : 32'd1);
            m_bubble = m_bubble + (kill ? 32'd1 : 32'd0);
        end
        m_pc = nxt;
        chk("prev_inst", prev_inst, m_prev);
        chk("ex_pc", ex_pc, m_ex_pc);
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        chk("fetch_cnt", fetch_cnt, m_fetch);
        chk("bubble_cnt", bubble_cnt, m_bubble);
    endtask

    initial begin
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        chk("rst_prev", prev_inst, NOP);
        chk("rst_fetch", fetch_cnt, 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, '0);
        chk("t1_prev", prev_inst, tag(32'h4000_000C));
        chk("t1_fetch", fetch_cnt, 32'd4);
        step(0, 0, 1, 0, '0);
        chk("t2_prev", prev_inst, NOP);
        chk("t2_ex_pc", ex_pc, 32'h4000_0010);
        chk("t2_bubble", bubble_cnt, 32'd1);
        step(0, 0, 0, 1, 32'h4000_0103);
        chk("t3_prev", prev_inst, NOP);
        step(0, 0, 0, 0, '0);
        chk("t3_target", prev_inst, tag(32'h4000_0100));
        chk("t3_ex_pc", ex_pc, 32'h4000_0100);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 32'h4000_0200);
        chk("t4_held", prev_inst, tag(32'h4000_0100));
        step(0, 0, 0, 1, 32'h4000_0200);
        step(0, 0, 0, 0, '0);
        chk("t4_target", prev_inst, tag(32'h4000_0200));
        step(0, 0, 1, 1, 32'h4000_0300);
        chk("both_bubble", bubble_cnt, 32'd4);
        step(0, 0, 0, 0, '0);
        chk("both_target", ex_pc, 32'h4000_0300);
        step(0, 1, 0, 1, 32'h4000_0400);
        step(1, 1, 0, 1, 32'h4000_0400);
        chk("t5_prev", prev_inst, NOP);
        chk("t5_valid", {31'd0, ex_valid}, 32'd0);
        chk("t5_cnts", fetch_cnt | bubble_cnt, 32'd0);
        step(0, 0, 0, 0, '0);
        chk("t5_ex_pc", ex_pc, RST_PC);
        step(0, 0, 0, 1, 32'hFFFF_FFFE);
        step(0, 0, 0, 0, '0);
        chk("t6_ex_pc", ex_pc, 32'hFFFF_FFFC);
        chk("t6_wrap_addr", m_pc, 32'h0000_0000);
        step(0, 0, 0, 0, '0);
        chk("t6_prev", prev_inst, tag(32'h0000_0000));
        chk("t6_no_x", {31'd0, $isunknown({icache_addr, prev_inst, ex_pc, ex_valid,
            fetch_cnt, bubble_cnt, icache_re})}, 32'd0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, $urandom);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
